// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: two-flop synchroniser, mid-bit sampling FSM,
// and a one-entry holding register with valid/ready handshake and error flags.
module uart_rx #(
  parameter int unsigned clocks_per_bit = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_rx,
  input  logic       rx_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_frame_err,
  output logic       out_overrun,
  output logic       out_busy
);

  localparam int unsigned CNT_W = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(clocks_per_bit / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(clocks_per_bit - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  logic rx_s;
  logic byte_done;
  logic consume;

  assign rx_s    = s2_q;
  assign consume = valid_q & rx_ready;

  // NOTE: every output of this block gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    s1_d        = in_rx;
    s2_d        = s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_RELOAD;
        end
      end

      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          cnt_d   = BIT_RELOAD;
        end
      end

      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          cnt_d   = BIT_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          // Leaving at mid-stop lets a start edge right after a short stop bit be caught.
          byte_done = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end

      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Consume first, so a byte landing on the same edge still leaves valid set.
    if (consume) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (byte_done) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  // from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_frame_err = frame_err_q;
  assign out_overrun   = overrun_q;
  assign out_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a behavioural 8N1 line driver feeds the receiver and
// each scenario task checks the outputs against hand-computed values.
module tb_uart_rx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_frame_err;
  logic       out_overrun;
  logic       out_busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int         fe_cnt = 0;
  logic       valid_prev = 1'b0;

  uart_rx #(.clocks_per_bit(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_rx        (in_rx),
    .rx_ready     (rx_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_frame_err(out_frame_err),
    .out_overrun  (out_overrun),
    .out_busy     (out_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records each rising edge of out_valid and every cycle out_frame_err is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !valid_prev) got_q.push_back(out_data);
      if (out_frame_err) fe_cnt = fe_cnt + 1;
    end
    valid_prev = out_valid;
  end

  // Called at a negedge; the first rising edge after the call is T0. Returns at the
  // negedge just before edge T0+10*CPB, where the stop bit is sampled.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int t0);
    in_rx = 1'b0;
    t0 = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    in_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_rx = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", out_data); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_vec++; if (out_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", out_frame_err); end
    n_vec++; if (out_overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0", out_overrun); end
    n_vec++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
    in_rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte;
    int t0;
    rx_ready = 1'b1;
    got_q.delete();
    send_byte(8'hA5, 1'b1, t0);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    n_vec++; if (cyc - t0 !== 40) begin n_err++; $display("FAIL single_latency got=%0d exp=40", cyc - t0); end
    n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL single_data got=%h exp=a5", out_data); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_onecycle got=%b exp=0", out_valid); end
    repeat (4) @(negedge clk);
    n_vec++; if (fe_cnt !== 0 || out_overrun !== 1'b0) begin
      n_err++; $display("FAIL single_flags ferr_cycles=%0d ovr=%b exp=0/0", fe_cnt, out_overrun);
    end
  endtask

  task automatic test_back_to_back;
    int t0;
    logic [7:0] exp_b [4];
    exp_b = '{8'h00, 8'hFF, 8'h55, 8'h80};
    rx_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) send_byte(exp_b[i], 1'b1, t0);
    repeat (10) @(negedge clk);
    n_vec++; if (got_q.size() !== 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= got_q.size()) begin
        n_err++; $display("FAIL b2b_byte%0d got=none exp=%h", i, exp_b[i]);
      end else if (got_q[i] !== exp_b[i]) begin
        n_err++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_b[i]);
      end
    end
    n_vec++; if (fe_cnt !== 0) begin n_err++; $display("FAIL b2b_ferr got=%0d exp=0", fe_cnt); end
    n_vec++; if (out_overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ovr got=%b exp=0", out_overrun); end
    n_vec++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy got=%b exp=0", out_busy); end
  endtask

  task automatic test_false_start;
    got_q.delete();
    in_rx = 1'b0;
    @(negedge clk);
    in_rx = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (out_busy !== 1'b1) begin n_err++; $display("FAIL glitch_start_seen got=%b exp=1", out_busy); end
    repeat (20) @(negedge clk);
    n_vec++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL glitch_back_idle got=%b exp=0", out_busy); end
    n_vec++; if (got_q.size() !== 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL glitch_no_byte got=%0d valid=%b exp=0/0", got_q.size(), out_valid);
    end
    n_vec++; if (fe_cnt !== 0) begin n_err++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_frame_err;
    int t0;
    got_q.delete();
    rx_ready = 1'b1;
    send_byte(8'h3C, 1'b0, t0);
    @(negedge clk);
    n_vec++; if (out_frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_pulse got=%b exp=1", out_frame_err); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ferr_novalid got=%b exp=0", out_valid); end
    @(negedge clk);
    n_vec++; if (out_frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_onecycle got=%b exp=0", out_frame_err); end
    repeat (18) @(negedge clk);
    n_vec++; if (out_busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_hold got=%b exp=1", out_busy); end
    in_rx = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL ferr_break_exit got=%b exp=0", out_busy); end
    n_vec++; if (fe_cnt !== 1) begin n_err++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
    send_byte(8'h3C, 1'b1, t0);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      n_err++; $display("FAIL ferr_recover got=%h valid=%b exp=3c/1", out_data, out_valid);
    end
    repeat (4) @(negedge clk);
    fe_cnt = 0;
  endtask

  task automatic test_overrun;
    int t0;
    rx_ready = 1'b0;
    send_byte(8'h11, 1'b1, t0);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_first got=%h v=%b o=%b exp=11/1/0", out_data, out_valid, out_overrun);
    end
    send_byte(8'h22, 1'b1, t0);
    @(negedge clk);
    n_vec++; if (out_data !== 8'h22) begin n_err++; $display("FAIL ovr_data got=%h exp=22", out_data); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
    n_vec++; if (out_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got=%b exp=1", out_overrun); end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_consume_valid got=%b exp=0", out_valid); end
    n_vec++; if (out_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_consume_clear got=%b exp=0", out_overrun); end
    // A consume landing on the same edge as a new byte is not an overrun.
    send_byte(8'h33, 1'b1, t0);
    @(negedge clk);
    send_byte(8'h44, 1'b1, t0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h44) begin
      n_err++; $display("FAIL same_edge_data got=%h v=%b exp=44/1", out_data, out_valid);
    end
    n_vec++; if (out_overrun !== 1'b0) begin n_err++; $display("FAIL same_edge_ovr got=%b exp=0", out_overrun); end
    rx_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL same_edge_drain got=%b exp=0", out_valid); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int t0;
    logic [7:0] b;
    b = 8'h7E;
    rx_ready = 1'b0;
    send_byte(8'h5A, 1'b1, t0);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      n_err++; $display("FAIL mid_held got=%h v=%b exp=5a/1", out_data, out_valid);
    end
    in_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    in_rx = b[4];
    repeat (2) @(negedge clk);
    n_vec++; if (out_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%b exp=1", out_busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_data got=%h exp=00", out_data); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    n_vec++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got=%b exp=0", out_busy); end
    n_vec++; if (out_overrun !== 1'b0 || out_frame_err !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_flags o=%b f=%b exp=0/0", out_overrun, out_frame_err);
    end
    in_rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rx_ready = 1'b1;
    send_byte(8'h7E, 1'b1, t0);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h7E) begin
      n_err++; $display("FAIL mid_after got=%h v=%b exp=7e/1", out_data, out_valid);
    end
    n_vec++; if (out_overrun !== 1'b0) begin n_err++; $display("FAIL mid_after_ovr got=%b exp=0", out_overrun); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_false_start;
    test_frame_err;
    test_overrun;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
